// File: rtl/rv32i_mem_arbiter.sv
// Two-port to one-port memory arbiter: serializes RV32I fetch and load/store
// requests onto a single shared memory port, with data priority and a bounded
// starvation counter that forces a pending fetch through.
module rv32i_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        instr_read,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_rdata,
    output logic        instr_resp,

    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_mbe,
    output logic [31:0] data_rdata,
    output logic        data_resp,

    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mbe,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INSTR   = 2'd1,
        DATA    = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_mbe_q, mem_mbe_d;
    logic [31:0]       instr_rdata_q, instr_rdata_d;
    logic [31:0]       data_rdata_q, data_rdata_d;

    logic              instr_resp_c;
    logic              data_resp_c;
    logic              data_req_c;

    assign data_req_c   = data_read | data_write;
    assign instr_resp_c = (state_q == INSTR) & mem_resp;
    assign data_resp_c  = (state_q == DATA) & mem_resp;

    // State and datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            starve_cnt_q  <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_mbe_q     <= '0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_mbe_q     <= mem_mbe_d;
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    // Next-state: arbitrate only in IDLE, data wins unless fetch is starved.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (data_req_c) begin
                    if (instr_read && (starve_cnt_q == STARVE_MAX)) begin
                        state_d = INSTR;
                    end else begin
                        state_d = DATA;
                    end
                end else if (instr_read) begin
                    state_d = INSTR;
                end
            end
            INSTR, DATA: begin
                if (mem_resp) begin
                    state_d = RECOVER;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Register next-values: latch the winner on grant, drop strobes on response.
    always_comb begin
        starve_cnt_d  = starve_cnt_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_mbe_d     = mem_mbe_q;
        instr_rdata_d = instr_resp_c ? mem_rdata : instr_rdata_q;
        data_rdata_d  = data_resp_c  ? mem_rdata : data_rdata_q;

        if (state_q == IDLE) begin
            if (state_d == DATA) begin
                mem_read_d  = data_read;
                mem_write_d = data_write;
                mem_addr_d  = data_addr;
                mem_wdata_d = data_wdata;
                mem_mbe_d   = data_mbe;
                if (instr_read) begin
                    if (starve_cnt_q < STARVE_MAX) begin
                        starve_cnt_d = CNT_W'(starve_cnt_q + CNT_W'(1));
                    end
                end else begin
                    starve_cnt_d = '0;
                end
            end else if (state_d == INSTR) begin
                mem_read_d   = 1'b1;
                mem_write_d  = 1'b0;
                mem_addr_d   = instr_addr;
                mem_wdata_d  = '0;
                mem_mbe_d    = 4'hF;
                starve_cnt_d = '0;
            end
        end

        if (((state_q == INSTR) || (state_q == DATA)) && mem_resp) begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_mbe     = mem_mbe_q;
    assign instr_resp  = instr_resp_c;
    assign data_resp   = data_resp_c;
    assign instr_rdata = instr_resp_c ? mem_rdata : instr_rdata_q;
    assign data_rdata  = data_resp_c  ? mem_rdata : data_rdata_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed testbench for rv32i_mem_arbiter: fetch, store, tie/starvation,
// stall stability and asynchronous reset mid-transaction.
module tb_rv32i_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        instr_read;
    logic [31:0] instr_addr;
    logic [31:0] instr_rdata;
    logic        instr_resp;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_mbe;
    logic [31:0] data_rdata;
    logic        data_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    int checks;
    int errors;

    rv32i_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_read (instr_read),
        .instr_addr (instr_addr),
        .instr_rdata(instr_rdata),
        .instr_resp (instr_resp),
        .data_read  (data_read),
        .data_write (data_write),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_mbe   (data_mbe),
        .data_rdata (data_rdata),
        .data_resp  (data_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mbe    (mem_mbe),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_read = 0; instr_addr = '0;
        data_read = 0; data_write = 0; data_addr = '0; data_wdata = '0; data_mbe = '0;
        mem_rdata = '0; mem_resp = 0;
        repeat (3) next_cycle();
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (mem_mbe !== 4'h0) begin errors++; $display("FAIL reset_mem_mbe: got %h want 0", mem_mbe); end
        checks++; if (instr_resp !== 1'b0 || data_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b%b want 00", instr_resp, data_resp); end
        checks++; if (instr_rdata !== 32'h0 || data_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", instr_rdata, data_rdata); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        // c0: request in IDLE
        next_cycle();
        instr_read = 1; instr_addr = 32'h60;
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL fetch_c0_read: got %b want 0", mem_read); end
        // c1: strobe up, memory waiting
        next_cycle(); #1;
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL fetch_c1_strobe: got r%b w%b want r1 w0", mem_read, mem_write); end
        checks++; if (mem_addr !== 32'h60 || mem_mbe !== 4'hF || mem_wdata !== 32'h0) begin errors++; $display("FAIL fetch_c1_bus: got %h %h %h want 60 f 0", mem_addr, mem_mbe, mem_wdata); end
        checks++; if (instr_resp !== 1'b0) begin errors++; $display("FAIL fetch_c1_resp: got %b want 0", instr_resp); end
        // c2: memory responds
        next_cycle();
        mem_resp = 1; mem_rdata = 32'h00000013;
        #1;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL fetch_c2_read: got %b want 1", mem_read); end
        checks++; if (instr_resp !== 1'b1 || data_resp !== 1'b0) begin errors++; $display("FAIL fetch_c2_resp: got i%b d%b want i1 d0", instr_resp, data_resp); end
        checks++; if (instr_rdata !== 32'h00000013) begin errors++; $display("FAIL fetch_c2_rdata: got %h want 00000013", instr_rdata); end
        // c3: RECOVER; requester immediately presents the next fetch
        next_cycle();
        mem_resp = 0; mem_rdata = 32'hDEADBEEF; instr_addr = 32'h64;
        #1;
        checks++; if (mem_read !== 1'b0 || instr_resp !== 1'b0) begin errors++; $display("FAIL fetch_c3_idle: got r%b resp%b want 0 0", mem_read, instr_resp); end
        checks++; if (instr_rdata !== 32'h00000013) begin errors++; $display("FAIL fetch_c3_hold: got %h want 00000013", instr_rdata); end
        // c4: IDLE samples, still no strobe
        next_cycle(); #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL fetch_c4_read: got %b want 0", mem_read); end
        // c5: second fetch on bus, zero-wait response
        next_cycle();
        mem_resp = 1; mem_rdata = 32'h00100093;
        #1;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h64) begin errors++; $display("FAIL fetch_c5_bus: got r%b %h want r1 64", mem_read, mem_addr); end
        checks++; if (instr_resp !== 1'b1 || instr_rdata !== 32'h00100093) begin errors++; $display("FAIL fetch_c5_resp: got %b %h want 1 00100093", instr_resp, instr_rdata); end
        next_cycle();
        mem_resp = 0; instr_read = 0;
    endtask

    task automatic test_store();
        next_cycle();
        data_write = 1; data_addr = 32'h104; data_wdata = 32'h0000AB00; data_mbe = 4'b0010;
        #1;
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL store_c0_write: got %b want 0", mem_write); end
        next_cycle();
        mem_resp = 1;
        #1;
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL store_c1_strobe: got w%b r%b want w1 r0", mem_write, mem_read); end
        checks++; if (mem_addr !== 32'h104 || mem_wdata !== 32'h0000AB00 || mem_mbe !== 4'b0010) begin errors++; $display("FAIL store_c1_bus: got %h %h %h want 104 0000ab00 2", mem_addr, mem_wdata, mem_mbe); end
        checks++; if (data_resp !== 1'b1 || instr_resp !== 1'b0) begin errors++; $display("FAIL store_c1_resp: got d%b i%b want d1 i0", data_resp, instr_resp); end
        next_cycle();
        mem_resp = 0; data_write = 0;
        #1;
        checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || data_resp !== 1'b0) begin errors++; $display("FAIL store_c2_done: got w%b r%b resp%b want 000", mem_write, mem_read, data_resp); end
    endtask

    task automatic test_tie_starvation();
        logic [9:0] is_instr;
        is_instr = 10'b1000010000; // bit i set => grant i is a fetch (D,D,D,D,I,D,D,D,D,I)
        next_cycle();
        instr_read = 1; instr_addr = 32'h200;
        data_read = 1; data_addr = 32'h300; data_wdata = 32'h0; data_mbe = 4'hF;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            mem_resp = 1; mem_rdata = 32'hA000_0000 + 32'(i);
            #1;
            if (is_instr[i]) begin
                checks++; if (mem_addr !== 32'h200 || mem_mbe !== 4'hF) begin errors++; $display("FAIL tie_grant%0d: got %h mbe %h want fetch 200 f", i, mem_addr, mem_mbe); end
                checks++; if (instr_resp !== 1'b1 || data_resp !== 1'b0) begin errors++; $display("FAIL tie_resp%0d: got i%b d%b want i1 d0", i, instr_resp, data_resp); end
            end else begin
                checks++; if (mem_addr !== 32'h300) begin errors++; $display("FAIL tie_grant%0d: got %h want data 300", i, mem_addr); end
                checks++; if (data_resp !== 1'b1 || instr_resp !== 1'b0 || data_rdata !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL tie_resp%0d: got d%b i%b %h want d1 i0 %h", i, data_resp, instr_resp, data_rdata, 32'hA000_0000 + 32'(i)); end
            end
            next_cycle();
            mem_resp = 0;
            #1;
            checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL tie_recover%0d: got %b want 0", i, mem_read); end
            next_cycle();
            if (i == 9) begin
                instr_read = 0; data_read = 0;
            end
        end
    endtask

    task automatic test_stability();
        next_cycle();
        data_read = 1; data_addr = 32'h400; data_wdata = 32'h1111; data_mbe = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            data_addr = 32'h500 + 32'(k); data_wdata = 32'(k);
            #1;
            checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h400 || mem_wdata !== 32'h1111) begin errors++; $display("FAIL stall%0d_bus: got r%b %h %h want r1 400 1111", k, mem_read, mem_addr, mem_wdata); end
            checks++; if (data_resp !== 1'b0) begin errors++; $display("FAIL stall%0d_resp: got %b want 0", k, data_resp); end
        end
        next_cycle();
        mem_resp = 1; mem_rdata = 32'hCAFEF00D;
        #1;
        checks++; if (data_resp !== 1'b1 || data_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_resp: got %b %h want 1 cafef00d", data_resp, data_rdata); end
        next_cycle();
        mem_resp = 0; data_read = 0;
        #1;
        checks++; if (data_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_hold: got %h want cafef00d", data_rdata); end
    endtask

    task automatic test_async_reset();
        next_cycle();
        data_read = 1; data_addr = 32'h700;
        next_cycle(); #1;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h700) begin errors++; $display("FAIL areset_pre: got r%b %h want r1 700", mem_read, mem_addr); end
        next_cycle();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mem_read !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL areset_immediate: got r%b %h want r0 0", mem_read, mem_addr); end
        next_cycle();
        rst = 1'b0; data_read = 0;
        mem_resp = 1; mem_rdata = 32'h12345678;
        #1;
        checks++; if (instr_resp !== 1'b0 || data_resp !== 1'b0) begin errors++; $display("FAIL areset_late_resp: got i%b d%b want 00", instr_resp, data_resp); end
        checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL areset_rdata: got %h want 0", data_rdata); end
        next_cycle();
        mem_resp = 0;
        instr_read = 1; instr_addr = 32'h80;
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL areset_idle: got %b want 0", mem_read); end
        next_cycle();
        mem_resp = 1; mem_rdata = 32'h00000513;
        #1;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL areset_fetch_bus: got r%b %h want r1 80", mem_read, mem_addr); end
        checks++; if (instr_resp !== 1'b1 || instr_rdata !== 32'h00000513) begin errors++; $display("FAIL areset_fetch_resp: got %b %h want 1 00000513", instr_resp, instr_rdata); end
        next_cycle();
        mem_resp = 0; instr_read = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_fetch();
        test_store();
        test_tie_starvation();
        test_stability();
        test_async_reset();
        repeat (2) next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Two-port to one-port memory arbiter between the 5-stage RV32I datapath and the single shared memory/cache port. It accepts the datapath's instruction-fetch request (IF) and data load/store request (MEM stage) and serializes them onto one request/response bus. It latches each granted request, holds it stable until the memory acknowledges, and returns the read data and a one-cycle response pulse to the requester that owns the transaction. Data requests normally win ties; a bounded starvation counter guarantees fetch progress.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before the fetch is forced; legal range 1–15.

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_read  in  1  fetch request; held high until instr_resp
- instr_addr  in  32  fetch byte address; bits [1:0] forwarded unchanged
- instr_rdata  out  32  fetched word; valid when instr_resp=1
- instr_resp  out  1  one-cycle fetch completion pulse
- data_read  in  1  load request; held until data_resp
- data_write  in  1  store request; held until data_resp; never with data_read
- data_addr  in  32  load/store byte address
- data_wdata  in  32  store data, already lane-shifted
- data_mbe  in  4  byte enables for stores
- data_rdata  out  32  load word; valid when data_resp=1
- data_resp  out  1  one-cycle load/store completion pulse
- mem_read  out  1  shared-port read strobe
- mem_write  out  1  shared-port write strobe
- mem_addr  out  32  shared-port address
- mem_wdata  out  32  shared-port write data
- mem_mbe  out  4  shared-port byte enables (4'hF on reads)
- mem_rdata  in  32  shared-port read data, valid with mem_resp
- mem_resp  in  1  shared-port completion, single-cycle pulse

## Operation
- FSM states: IDLE, INSTR, DATA, RECOVER.
- IDLE: requests are sampled only in this state.
  - Data pending: go to DATA.
  - Only fetch pending: go to INSTR.
  - Both pending and starve_cnt == STARVE_LIMIT: go to INSTR.
  - Otherwise both pending: go to DATA.
- On grant, register mem_addr, mem_wdata and mem_mbe from the winner.
  - Data grant: mem_read = data_read, mem_write = data_write.
  - Instr grant: mem_read = 1, mem_write = 0, mem_mbe = 4'hF, mem_wdata = 0.
- INSTR / DATA: mem_* outputs are held constant until mem_resp.
  - On mem_resp: mem_read and mem_write drop at the next edge; next state RECOVER.
- instr_resp = (state==INSTR) & mem_resp, combinational.
- data_resp = (state==DATA) & mem_resp, combinational.
- instr_rdata and data_rdata pass mem_rdata through while the matching resp is high, and hold their last captured value otherwise.
- RECOVER: lasts exactly one cycle and ignores all requests, which gives the requester time to drop or replace its request. Next state IDLE.
- starve_cnt, 4 bits:
  - Increment on a DATA grant made while instr_read=1, saturating at STARVE_LIMIT.
  - Clear on any INSTR grant.
  - Clear on a DATA grant made while instr_read=0.
- data_read and data_write both high is illegal; the arbiter does not check for it.

## Timing
- Reset (async, immediate) values:
  - State IDLE, starve_cnt 0.
  - mem_read, mem_write, instr_resp, data_resp: 0.
  - mem_addr, mem_wdata, mem_mbe, instr_rdata, data_rdata: 0.
- Reset during INSTR or DATA abandons the in-flight transaction; a late mem_resp after reset is ignored.
- Request to bus latency: request high in IDLE at cycle t gives mem_read/mem_write high from t+1.
- With a memory responding in L cycles, resp pulses at t+L. Zero wait gives L=1.
- Turnaround: mem_resp in cycle r puts RECOVER at r+1, IDLE at r+2, and the earliest next strobe at r+3.
- Back-to-back throughput with a zero-wait memory: one transaction per 3 cycles.
- mem_resp while in IDLE or RECOVER is ignored.
- A requester dropping its request before resp: the transaction still completes and resp still pulses.

## Test plan
- Single fetch: reset, instr_read=1, instr_addr=0x60, memory returns 0x00000013 after 2 cycles.
  - mem_read high cycles 1–2, mem_mbe=F.
  - instr_resp pulses cycle 2 with instr_rdata=0x13.
  - No mem strobe in cycles 3–4.
- Store: data_write=1, addr 0x104, wdata 0xAB00, mbe 4'b0010, zero-wait memory.
  - mem_write for one cycle with those exact values.
  - data_resp pulses once; mem_read stays 0.
- Tie and starvation: instr_read and data_read both held high with STARVE_LIMIT=4, data request re-asserted after each response.
  - Grant order is D,D,D,D,I,D,D,D,D,I.
  - starve_cnt returns to 0 after each I grant.
- Stability: memory stalls 10 cycles while the requester changes data_addr mid-transaction.
  - mem_addr and mem_wdata stay at their grant-time values.
  - data_resp arrives only with mem_resp.
- Async reset mid-DATA: assert rst between clock edges during a stall.
  - mem_read falls before the next edge.
  - A late mem_resp after rst release produces no resp.
  - The next instr_read is serviced normally.
